// File: rtl/boxhead_pkg.sv
// boxhead_pkg: shared enemy FSM/direction types and sprite footprint constants
package boxhead_pkg;
    typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_e;
    typedef enum logic [1:0] {DOWN, LEFT, UP, RIGHT} dir_e;
    localparam int ENEMY_W  = 26;
    localparam int ENEMY_H  = 26;
    localparam int PLAYER_W = 18;
    localparam int PLAYER_H = 20;
endpackage

// File: rtl/enemy_hit_test.sv
// enemy_hit_test: combinational overlap test of player attack box vs enemy box
// Ports: player_x_i/player_y_i/dir_i player position and facing; enemy_x_i/enemy_y_i
// enemy position; hit_o high when the boxes strictly overlap. 10-bit math avoids overflow.
module enemy_hit_test
    import boxhead_pkg::*;
#(
    parameter int ATTACK_REACH = 12
) (
    input  logic [8:0] player_x_i,
    input  logic [8:0] player_y_i,
    input  dir_e       dir_i,
    input  logic [8:0] enemy_x_i,
    input  logic [8:0] enemy_y_i,
    output logic       hit_o
);
    localparam logic [9:0] R = 10'(ATTACK_REACH);
    logic [9:0] px, py, ex, ey, x0, x1, y0, y1;
    always_comb begin
        px = {1'b0, player_x_i};
        py = {1'b0, player_y_i};
        ex = {1'b0, enemy_x_i};
        ey = {1'b0, enemy_y_i};
        // left/up extensions clamp at the screen origin
        x0 = (dir_i == LEFT) ? (px >= R ? px - R : 10'd0) : px;
        y0 = (dir_i == UP)   ? (py >= R ? py - R : 10'd0) : py;
        x1 = px + 10'(PLAYER_W) + ((dir_i == RIGHT) ? R : 10'd0);
        y1 = py + 10'(PLAYER_H) + ((dir_i == DOWN)  ? R : 10'd0);
        hit_o = (x0 < ex + 10'(ENEMY_W)) && (ex < x1) &&
                (y0 < ey + 10'(ENEMY_H)) && (ey < y1);
    end
endmodule

// File: rtl/enemy_combat.sv
// enemy_combat: per-frame enemy hit/kill/damage FSM (ALIVE/HIT/DEAD)
// Ports: Clk, Reset_n (async active-low), game_frame_clk_rising_edge frame strobe;
// Player_X/Y/Direction/Attack, Obj_X_Pos/Obj_Y_Pos, Enemy_Attack_Ready in;
// Enemy_Is_Attacked, is_alive, Enemy_HP, Player_Damage (pulse), Kill (pulse) out.
// Define ENEMY_RESPAWN_EN to make DEAD respawn after RESPAWN_FRAMES strobes.
module enemy_combat
    import boxhead_pkg::*;
#(
    parameter int ENEMY_HP        = 3,
    parameter int ATTACK_REACH    = 12,
    parameter int ATTACK_COOLDOWN = 30,
    parameter int RESPAWN_FRAMES  = 120
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       game_frame_clk_rising_edge,
    input  logic [8:0] Player_X,
    input  logic [8:0] Player_Y,
    input  logic [1:0] Player_Direction,
    input  logic       Player_Attack,
    input  logic [8:0] Obj_X_Pos,
    input  logic [8:0] Obj_Y_Pos,
    input  logic       Enemy_Attack_Ready,
    output logic       Enemy_Is_Attacked,
    output logic       is_alive,
    output logic [2:0] Enemy_HP,
    output logic       Player_Damage,
    output logic       Kill
);
    localparam int CW = $clog2(ATTACK_COOLDOWN + 2);
    state_e        state_q, state_d;
    logic [2:0]    hp_q, hp_d;
    logic [CW-1:0] cd_q, cd_d, cd_dec;
    logic          atk_q, dmg_q, dmg_d, kill_q, kill_d, hit, landed;
    enemy_hit_test #(.ATTACK_REACH(ATTACK_REACH)) u_hit (
        .player_x_i(Player_X),
        .player_y_i(Player_Y),
        .dir_i     (dir_e'(Player_Direction)),
        .enemy_x_i (Obj_X_Pos),
        .enemy_y_i (Obj_Y_Pos),
        .hit_o     (hit)
    );
`ifdef ENEMY_RESPAWN_EN
    localparam int RW = $clog2(RESPAWN_FRAMES + 1);
    logic [RW-1:0] rsp_q, rsp_d;
`endif
    always_comb begin
        landed  = (state_q == ALIVE) && Player_Attack && !atk_q && hit;
        // damage readiness is judged on the already-decremented count so pulses
        // land exactly ATTACK_COOLDOWN strobes apart
        cd_dec  = (cd_q == '0) ? '0 : cd_q - 1'b1;
        state_d = state_q;
        hp_d    = hp_q;
        cd_d    = cd_q;
        dmg_d   = 1'b0;
        kill_d  = 1'b0;
`ifdef ENEMY_RESPAWN_EN
        rsp_d   = rsp_q;
`endif
        if (game_frame_clk_rising_edge) begin
            cd_d = cd_dec;
            if (state_q == ALIVE) begin
                if (landed) begin
                    hp_d    = hp_q - 3'd1;
                    state_d = (hp_d == 3'd0) ? DEAD : HIT;
                    kill_d  = (hp_d == 3'd0);
                end else if (Enemy_Attack_Ready && cd_dec == '0) begin
                    dmg_d = 1'b1;
                    cd_d  = CW'(ATTACK_COOLDOWN);
                end
            end else if (state_q == HIT) begin
                state_d = ALIVE;
            end else begin
`ifdef ENEMY_RESPAWN_EN
                rsp_d = rsp_q + 1'b1;
                if (rsp_q == RW'(RESPAWN_FRAMES - 1)) begin
                    state_d = ALIVE;
                    hp_d    = 3'(ENEMY_HP);
                    cd_d    = '0;
                    rsp_d   = '0;
                end
`endif
            end
        end
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ALIVE;
            hp_q    <= 3'(ENEMY_HP);
            cd_q    <= '0;
            atk_q   <= 1'b0;
            dmg_q   <= 1'b0;
            kill_q  <= 1'b0;
`ifdef ENEMY_RESPAWN_EN
            rsp_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            cd_q    <= cd_d;
            atk_q   <= game_frame_clk_rising_edge ? Player_Attack : atk_q;
            dmg_q   <= dmg_d;
            kill_q  <= kill_d;
`ifdef ENEMY_RESPAWN_EN
            rsp_q   <= rsp_d;
`endif
        end
    end
    assign Enemy_Is_Attacked = (state_q == HIT);
    assign is_alive          = (state_q != DEAD);
    assign Enemy_HP          = hp_q;
    assign Player_Damage     = dmg_q;
    assign Kill              = kill_q;
endmodule
